// File: rtl/lsu_pkg.sv
// Shared encodings and the alignment rule for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2,
    SIZE_ILL  = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Illegal size or an address that is not naturally aligned for the size.
  function automatic logic access_error(input size_e size, input logic [1:0] addr_lo);
    logic err;
    case (size)
      SIZE_BYTE: err = 1'b0;
      SIZE_HALF: err = addr_lo[0];
      SIZE_WORD: err = (addr_lo != 2'b00);
      default:   err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian lane extraction for loads and lane merge for stores.
module mem_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  size_e       size,
  input  logic        is_signed,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = word[31:24];
      2'd1:    byte_sel = word[23:16];
      2'd2:    byte_sel = word[15:8];
      default: byte_sel = word[7:0];
    endcase
    half_sel = addr_lo[1] ? word[15:0] : word[31:16];
  end

  always_comb begin
    load_data  = '0;
    store_word = word;
    case (size)
      SIZE_BYTE: begin
        load_data = is_signed ? {{24{byte_sel[7]}}, byte_sel} : {24'h0, byte_sel};
        case (addr_lo)
          2'd0:    store_word[31:24] = wdata[7:0];
          2'd1:    store_word[23:16] = wdata[7:0];
          2'd2:    store_word[15:8]  = wdata[7:0];
          default: store_word[7:0]   = wdata[7:0];
        endcase
      end
      SIZE_HALF: begin
        load_data = is_signed ? {{16{half_sel[15]}}, half_sel} : {16'h0, half_sel};
        if (addr_lo[1]) store_word[15:0]  = wdata[15:0];
        else            store_word[31:16] = wdata[15:0];
      end
      SIZE_WORD: begin
        load_data  = word;
        store_word = wdata;
      end
      default: begin
        load_data  = '0;
        store_word = word;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: byte/half/word loads and stores, read-modify-write
// for sub-word stores, alignment checking before any memory access.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_error,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_write_en,
  output logic                  mem_read_en,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  size_e                 size_q, size_d;
  logic                  signed_q, signed_d;
  logic                  write_q, write_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;

  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] store_word;

  mem_lane_align u_align (
    .word       (word_q),
    .addr_lo    (addr_q[1:0]),
    .size       (size_q),
    .is_signed  (signed_q),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      size_q   <= SIZE_BYTE;
      signed_q <= 1'b0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      wdata_q  <= '0;
      word_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      write_q  <= write_d;
      err_q    <= err_d;
      wdata_q  <= wdata_d;
      word_q   <= word_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    size_d   = size_q;
    signed_d = signed_q;
    write_d  = write_q;
    err_d    = err_q;
    wdata_d  = wdata_q;
    word_d   = word_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d   = req_addr;
          size_d   = size_e'(req_size);
          signed_d = req_signed;
          write_d  = req_write;
          wdata_d  = req_wdata;
          err_d    = access_error(size_e'(req_size), req_addr[1:0]);
          if (err_d)                                  state_d = RESP;
          else if (req_write && req_size == SIZE_WORD) state_d = WRITE;
          else                                        state_d = READ;
        end
      end
      READ: begin
        word_d  = mem_data_out;
        state_d = write_q ? WRITE : RESP;
      end
      WRITE:   state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready    = (state_q == IDLE);
    mem_read_en  = (state_q == READ);
    mem_write_en = (state_q == WRITE);
    mem_address  = {2'b00, addr_q[ADDR_WIDTH-1:2]};
    mem_data_in  = (state_q == WRITE) ? store_word : '0;
    resp_valid   = (state_q == RESP);
    resp_error   = (state_q == RESP) && err_q;
    resp_rdata   = (state_q == RESP && !write_q && !err_q) ? load_data : '0;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a small word-addressed memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mem_address;
  logic        mem_write_en;
  logic        mem_read_en;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;

  load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_signed   (req_signed),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_error   (resp_error),
    .mem_address  (mem_address),
    .mem_write_en (mem_write_en),
    .mem_read_en  (mem_read_en),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out)
  );

  always #5 clk = ~clk;

  // Memory model; a recognisable junk value when not enabled exposes stray sampling.
  logic [31:0] mem [0:15];
  assign mem_data_out = mem_read_en ? mem[mem_address[3:0]] : 32'hDEAD_BEEF;
  always @(posedge clk) if (mem_write_en) mem[mem_address[3:0]] <= mem_data_in;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  int          rd_cycles, wr_cycles;
  logic [31:0] wr_addr, wr_data;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset_n) begin
      checks++;
      if (mem_read_en && mem_write_en) begin
        failures++;
        $display("FAIL rd_wr_exclusive: read_en=%0b write_en=%0b, required not both 1", mem_read_en, mem_write_en);
      end
      if (req_valid && req_ready) acc_q.push_back(cyc + 1);
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_resp: resp_valid=1 at cycle %0d, required no response", cyc);
        end else begin
          exp_t e;
          int   a;
          e = exp_q.pop_front();
          a = (acc_q.size() != 0) ? acc_q.pop_front() : -1000;
          checks++;
          if (resp_rdata !== e.rdata) begin
            failures++;
            $display("FAIL resp_rdata: got %08h, required %08h", resp_rdata, e.rdata);
          end
          checks++;
          if (resp_error !== e.err) begin
            failures++;
            $display("FAIL resp_error: got %0b, required %0b", resp_error, e.err);
          end
          checks++;
          if (cyc - a + 1 != e.lat) begin
            failures++;
            $display("FAIL latency: got %0d, required %0d", cyc - a + 1, e.lat);
          end
        end
      end
    end
  end

  // Reference load: shift the addressed lane to the top, then extend.
  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] a,
                                           input logic [1:0] sz, input logic sg);
    logic [31:0] s;
    s = w << (8 * a);
    if (sz == 2'd0) return sg ? {{24{s[31]}}, s[31:24]} : {24'h0, s[31:24]};
    if (sz == 2'd1) return sg ? {{16{s[31]}}, s[31:16]} : {16'h0, s[31:16]};
    return w;
  endfunction

  function automatic exp_t mk_exp(input logic [31:0] r, input logic e, input int l);
    exp_t x;
    x.rdata = r;
    x.err   = e;
    x.lat   = l;
    return x;
  endfunction

  // Issue one request and wait (bounded) for its response; records memory activity.
  task automatic run_req(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
    bit accepted = 0;
    bit done = 0;
    rd_cycles = 0;
    wr_cycles = 0;
    wr_addr   = '0;
    wr_data   = '0;
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr  = a;    req_wdata = wd;
    for (int i = 0; i < 12 && !done; i++) begin
      @(negedge clk);
      if (mem_read_en) rd_cycles++;
      if (mem_write_en) begin
        wr_cycles++;
        wr_addr = mem_address;
        wr_data = mem_data_in;
      end
      if (resp_valid) done = 1;
      if (req_valid && req_ready) accepted = 1;
      @(posedge clk);
      #1;
      if (accepted) req_valid = 1'b0;
    end
    req_valid = 1'b0;
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL resp_timeout: no resp_valid within 12 cycles for addr %08h, required one", a);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    req_valid = 0; req_write = 0; req_size = 0; req_signed = 0; req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({req_ready, resp_valid, resp_error, mem_write_en, mem_read_en} !== 5'b10000) begin
      failures++;
      $display("FAIL reset_ctrl: ready/rv/err/we/re=%05b, required 10000",
               {req_ready, resp_valid, resp_error, mem_write_en, mem_read_en});
    end
    checks++;
    if ({resp_rdata, mem_address, mem_data_in} !== 96'h0) begin
      failures++;
      $display("FAIL reset_data: rdata=%08h addr=%08h din=%08h, required all 0",
               resp_rdata, mem_address, mem_data_in);
    end
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_word_store;
    exp_q.push_back(mk_exp(32'h0, 1'b0, 2));
    run_req(1'b1, 2'd2, 1'b0, 32'h0, 32'h8899_AABB);
    checks++;
    if (wr_cycles != 1 || rd_cycles != 0) begin
      failures++;
      $display("FAIL sw_mem_cycles: wr=%0d rd=%0d, required wr=1 rd=0", wr_cycles, rd_cycles);
    end
    checks++;
    if (wr_addr !== 32'h0 || wr_data !== 32'h8899_AABB) begin
      failures++;
      $display("FAIL sw_bus: addr=%08h data=%08h, required 00000000 8899aabb", wr_addr, wr_data);
    end
    checks++;
    if (mem[0] !== 32'h8899_AABB) begin
      failures++;
      $display("FAIL sw_memory: mem[0]=%08h, required 8899aabb", mem[0]);
    end
  endtask

  task automatic test_loads;
    logic [1:0]  sz [6] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
    logic        sg [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] ad [6] = '{32'h1, 32'h1, 32'h2, 32'h0, 32'h3, 32'h0};
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(mk_exp(ref_load(mem[0], ad[i][1:0], sz[i], sg[i]), 1'b0, 2));
      run_req(1'b0, sz[i], sg[i], ad[i], 32'hFFFF_FFFF);
      checks++;
      if (wr_cycles != 0 || rd_cycles != 1) begin
        failures++;
        $display("FAIL load_mem_cycles[%0d]: wr=%0d rd=%0d, required wr=0 rd=1", i, wr_cycles, rd_cycles);
      end
    end
  endtask

  task automatic test_half_store;
    exp_q.push_back(mk_exp(32'h0, 1'b0, 3));
    run_req(1'b1, 2'd1, 1'b0, 32'h2, 32'h0000_1234);
    checks++;
    if (wr_cycles != 1 || rd_cycles != 1) begin
      failures++;
      $display("FAIL sh_mem_cycles: wr=%0d rd=%0d, required wr=1 rd=1", wr_cycles, rd_cycles);
    end
    checks++;
    if (wr_data !== 32'h8899_1234) begin
      failures++;
      $display("FAIL sh_merge: data=%08h, required 88991234", wr_data);
    end
    checks++;
    if (mem[0] !== 32'h8899_1234) begin
      failures++;
      $display("FAIL sh_memory: mem[0]=%08h, required 88991234", mem[0]);
    end
  endtask

  task automatic test_errors;
    logic        wr [3] = '{1'b0, 1'b1, 1'b0};
    logic [1:0]  sz [3] = '{2'd1, 2'd2, 2'd3};
    logic [31:0] ad [3] = '{32'h1, 32'h6, 32'h0};
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(mk_exp(32'h0, 1'b1, 1));
      run_req(wr[i], sz[i], 1'b1, ad[i], 32'h1111_2222);
      checks++;
      if (wr_cycles != 0 || rd_cycles != 0) begin
        failures++;
        $display("FAIL err_mem_cycles[%0d]: wr=%0d rd=%0d, required 0 0", i, wr_cycles, rd_cycles);
      end
    end
    checks++;
    if (mem[1] !== 32'hCAFE_F00D) begin
      failures++;
      $display("FAIL err_memory: mem[1]=%08h, required cafef00d", mem[1]);
    end
  endtask

  task automatic test_reset_in_write;
    bit in_write = 0;
    bit accepted = 0;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0;
    req_addr  = 32'h3; req_wdata = 32'h0000_00EE;
    for (int i = 0; i < 6 && !in_write; i++) begin
      @(negedge clk);
      if (mem_write_en) in_write = 1;
      else begin
        if (req_valid && req_ready) accepted = 1;
        @(posedge clk);
        #1;
        if (accepted) req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    checks++;
    if (!in_write) begin
      failures++;
      $display("FAIL rst_write_reach: WRITE state not observed, required within 6 cycles");
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (mem_write_en !== 1'b0) begin
      failures++;
      $display("FAIL rst_write_drop: write_en=%0b, required 0", mem_write_en);
    end
    checks++;
    if ({req_ready, resp_valid, resp_error, mem_read_en} !== 4'b1000 ||
        {resp_rdata, mem_address, mem_data_in} !== 96'h0) begin
      failures++;
      $display("FAIL rst_write_outputs: ready/rv/err/re=%04b rdata=%08h addr=%08h din=%08h, required 1000 and zeros",
               {req_ready, resp_valid, resp_error, mem_read_en}, resp_rdata, mem_address, mem_data_in);
    end
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    acc_q.delete();
    checks++;
    if (mem[0] !== 32'h8899_1234) begin
      failures++;
      $display("FAIL rst_write_memory: mem[0]=%08h, required 88991234", mem[0]);
    end
    reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back;
    int accepts = 0;
    int resps = 0;
    int last_resp = -100;
    exp_q.push_back(mk_exp(32'hCAFE_F00D, 1'b0, 2));
    exp_q.push_back(mk_exp(32'hCAFE_F00D, 1'b0, 2));
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0;
    req_addr  = 32'h4; req_wdata = '0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (accepts == 1 && resps == 0) begin
        checks++;
        if (req_ready !== 1'b0) begin
          failures++;
          $display("FAIL b2b_ready_busy: req_ready=%0b at step %0d, required 0", req_ready, i);
        end
      end
      if (resp_valid) begin
        resps++;
        last_resp = i;
      end
      if (req_valid && req_ready) begin
        accepts++;
        if (accepts == 2) begin
          checks++;
          if (i - last_resp != 1) begin
            failures++;
            $display("FAIL b2b_second_accept: gap=%0d after first resp, required 1", i - last_resp);
          end
        end
      end
      @(posedge clk);
      #1;
      if (accepts == 2) req_valid = 1'b0;
    end
    req_valid = 1'b0;
    checks++;
    if (accepts != 2 || resps != 2) begin
      failures++;
      $display("FAIL b2b_counts: accepts=%0d resps=%0d, required 2 and 2", accepts, resps);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[1] = 32'hCAFE_F00D;
    test_reset();
    test_word_store();
    test_loads();
    test_half_store();
    test_errors();
    test_reset_in_write();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d responses outstanding, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
